// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_EN.
package fetch_pkg;

    localparam int          BUF_DEPTH      = 2;
    localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } fetch_state_e;

    // Default-width view of one buffered fetch, as seen by decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch FIFO holding {pc, insn}; flush empties it in one cycle.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic [1:0] count_reg;

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && !flush && wr_ptr_reg == 1'(gi)) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign count = count_reg;
    assign head  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, 2-deep buffer to decode,
// redirect flush with in-flight drain. Define FETCH_MISALIGN_EN to trap misaligned redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [6:0]        opcode_o,
    output logic              misalign_o
);

    localparam int EW = AWIDTH + DWIDTH;

    fetch_state_e      state_reg, state_next;
    logic [AWIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [AWIDTH-1:0] req_addr_reg;
    logic [AWIDTH-1:0] redir_pc;
    logic [1:0]        count;
    logic [EW-1:0]     head;
    logic              accept;
    logic              buf_push;
    logic              buf_pop;

`ifdef FETCH_MISALIGN_EN
    logic misalign_reg, misalign_next;
    logic redir_bad;
    assign redir_pc   = redirect_pc_i;
    assign redir_bad  = redirect_pc_i[1:0] != 2'b00;
    assign misalign_o = !reset && misalign_reg;
`else
    assign redir_pc   = redirect_pc_i & ~AWIDTH'(3);
    assign misalign_o = 1'b0;
`endif

    assign accept  = imem_req_o && imem_ready_i;
    assign buf_pop = insn_valid_o && insn_ready_i && !redirect_i;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        buf_push      = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misalign_next = misalign_reg;
`endif
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (accept) begin
                    state_next    = ST_WAIT;
                    fetch_pc_next = fetch_pc_reg + AWIDTH'(4);
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    buf_push   = 1'b1;
                    state_next = (count + 2'd1 - 2'(buf_pop) < 2'd2) ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (count - 2'(buf_pop) < 2'd2) state_next = ST_REQ;
            end
            ST_DRAIN: begin
`ifdef FETCH_MISALIGN_EN
                if (imem_rvalid_i) state_next = misalign_reg ? ST_HALTED : ST_REQ;
`else
                if (imem_rvalid_i) state_next = ST_REQ;
`endif
            end
            default: state_next = state_reg;
        endcase

        // Redirect overrides everything; an owed response forces a trip through DRAIN.
        if (redirect_i && state_reg != ST_HALTED) begin
            buf_push      = 1'b0;
            fetch_pc_next = redir_pc;
            if (accept || ((state_reg == ST_WAIT || state_reg == ST_DRAIN) && !imem_rvalid_i)) begin
                state_next = ST_DRAIN;
`ifdef FETCH_MISALIGN_EN
            end else if (redir_bad || misalign_reg) begin
                state_next = ST_HALTED;
`endif
            end else begin
                state_next = ST_REQ;
            end
`ifdef FETCH_MISALIGN_EN
            if (redir_bad) misalign_next = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= BASEADDR;
            req_addr_reg <= '0;
`ifdef FETCH_MISALIGN_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (accept) req_addr_reg <= fetch_pc_reg;
`ifdef FETCH_MISALIGN_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    fetch_buf #(.WIDTH(EW)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data ({req_addr_reg, imem_rdata_i}),
        .pop       (buf_pop),
        .flush     (redirect_i),
        .count     (count),
        .head      (head)
    );

    assign imem_req_o   = !reset && state_reg == ST_REQ;
    assign imem_addr_o  = imem_req_o ? fetch_pc_reg : '0;
    assign insn_valid_o = !reset && count != 2'd0;
    assign insn_o       = insn_valid_o ? head[DWIDTH-1:0] : '0;
    assign pc_o         = insn_valid_o ? head[EW-1:DWIDTH] : '0;
    assign opcode_o     = insn_o[6:0];

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle instruction fetch sequencer for the pd-series core.
- Issues requests to instruction memory using a request/ready plus response-valid handshake, and keeps the fetch PC.
- Buffers up to two fetched instructions, each with its PC, for the decode stage (opcode extraction, immediate generation, register read).
- Handles control-flow redirects from execute, including discarding an in-flight response.

Parameters:
- AWIDTH, 32, address / PC width
- DWIDTH, 32, instruction width
- BASEADDR, 32'h0100_0000, PC value after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  AWIDTH  fetch address, word aligned
- imem_ready_i  in  1  memory accepts request this cycle when high with imem_req_o
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  DWIDTH  response instruction
- redirect_i  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc_i  in  AWIDTH  new fetch PC
- insn_valid_o  out  1  head buffer entry valid
- insn_ready_i  in  1  decode consumes head entry when high with insn_valid_o
- insn_o  out  DWIDTH  head instruction
- pc_o  out  AWIDTH  PC of head instruction
- opcode_o  out  7  insn_o[6:0], combinational
- misalign_o  out  1  misaligned redirect flag (only with FETCH_MISALIGN_EN; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- While reset is high: state=IDLE, fetch_pc=BASEADDR, buffer empty, outstanding=0.
- Output values during reset: imem_req_o=0, imem_addr_o=0, insn_valid_o=0, insn_o=0, pc_o=0, misalign_o=0.
- Reset mid-transaction: any in-flight response is dropped. Memory must not return data for a request accepted before reset.
- States:
  - IDLE: one cycle after reset deasserts, then REQ.
  - REQ: imem_req_o=1, imem_addr_o=fetch_pc. On imem_ready_i, go to WAIT and set fetch_pc += 4. Wraps modulo 2^AWIDTH, so 32'hFFFF_FFFC becomes 0.
  - WAIT: imem_req_o=0. On imem_rvalid_i, push {fetch address, imem_rdata_i} into the buffer. Next state is REQ if post-update count <2, else HOLD.
  - HOLD: buffer full. Go to REQ in the cycle after count drops below 2.
  - DRAIN: a response for a flushed request is still owed. Discard it on imem_rvalid_i, then go to REQ.
- Only one outstanding request at a time. A request is issued only when count<2, so a response never finds the buffer full.
- Buffer: 2-entry FIFO.
  - insn_valid_o = (count!=0). insn_o and pc_o show the head entry, and are 0 when the buffer is empty.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: reset release, then IDLE (1 cycle), REQ, WAIT. With a 1-cycle memory, the first insn_valid_o rises 1 cycle after imem_rvalid_i.
  - A response is never forwarded combinationally to the outputs.
- Redirect (highest priority):
  - Buffer is flushed (count=0) and fetch_pc=redirect_pc_i.
  - If a request is outstanding, go to DRAIN. This covers being in WAIT without rvalid, and being in REQ with imem_ready_i high in the same cycle.
  - Redirect in WAIT with imem_rvalid_i in the same cycle: the response is discarded and the next state is REQ.
  - Redirect in IDLE, HOLD or REQ without acceptance: next state is REQ.
  - Redirect in DRAIN: fetch_pc updates and the block stays in DRAIN.
  - Redirect with insn_ready_i in the same cycle: the flush wins and the pop has no further effect.
- Without FETCH_MISALIGN_EN: redirect_pc_i[1:0] is forced to 0.

Optional Feature:
- FETCH_MISALIGN_EN
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 asserts misalign_o sticky from the next cycle.
  - State goes to HALTED (after DRAIN if a request is outstanding). No further requests are issued; only reset clears HALTED.
- Undefined: the HALTED state is absent, misalign_o is constant 0, and the address is aligned by masking.

Decomposition:
- fetch_pkg:
  - fetch_state_e enum (IDLE, REQ, WAIT, HOLD, DRAIN, HALTED)
  - BUF_DEPTH=2
  - default BASEADDR constant
  - fetch_entry_t struct {pc, insn}
- Sub-module fetch_buf: 2-entry FIFO with push, pop, flush, count, head. It is the one natural sub-module.

Test Plan:
- Reset release with 1-cycle memory and insn_ready_i=1: requests at 0x0100_0000, 0x0100_0004, 0x0100_0008. Outputs show pc_o/insn_o in order with no duplicates or gaps.
- insn_ready_i=0: after two responses, count=2, state HOLD, imem_req_o=0. Raise insn_ready_i for 1 cycle: REQ resumes the next cycle at the next sequential PC.
- Redirect to 0x0100_0200 while in WAIT: the buffer empties immediately. The pending response (0xDEAD_BEEF) is discarded in DRAIN. The next request uses 0x0100_0200, and the first valid pc_o is 0x0100_0200.
- Redirect in the same cycle as imem_rvalid_i: the response is dropped, the next cycle is REQ at the redirect PC, and insn_valid_o stays 0.
- fetch_pc=0xFFFF_FFFC: the request after it uses address 0x0000_0000.
- Redirect to 0x0100_0002:
  - With FETCH_MISALIGN_EN: misalign_o=1 from the next cycle and no further imem_req_o.
  - Without it: the next request is at 0x0100_0000.
